instruction_queue_dual: RTL and testbench
=========================================

# instruction_queue_dual

Two-wide successor to the single-entry-per-cycle instruction queue, sitting between fetch and issue in the Tomasulo front end. Accepts up to two fetched instructions per cycle, each with its branch-prediction bundle, and presents the two oldest entries to a dual-issue stage, which may consume zero, one or two per cycle. Depth is parametrised. Flush on misprediction empties the queue in one cycle.

## Interface
- Entry bundle, 97 bits, packed MSB→LSB: {pred_target[31:0], pred, pc[31:0], inst[31:0]}; inst uses `InstBus`, pc and pred_target use `InstAddrBus`.
- `DEPTH`, default 16: number of entries; must equal 2**`PTR_WIDTH`, minimum 4.
- `PTR_WIDTH`, default 4: pointer width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous queue clear on misprediction.
- we  in  2  write enables; we[1] honoured only when we[0]=1.
- wdata0_i  in  97  entry for slot 0 (older).
- wdata1_i  in  97  entry for slot 1 (younger).
- wr_ready  out  1  at least 2 free entries.
- re  in  2  read enables; re[1] honoured only when re[0]=1.
- rdata0_o  out  97  oldest entry (head).
- rdata1_o  out  97  second-oldest entry (head+1, modulo DEPTH).
- rvalid  out  2  rvalid[0] = count≥1, rvalid[1] = count≥2.
- count_o  out  PTR_WIDTH+1  current occupancy, 0..DEPTH.

## Operation
- Circular buffer with w_ptr, r_ptr (PTR_WIDTH bits, natural wrap) and count (PTR_WIDTH+1 bits).
- Write request n_wr = 0, 1 (we=01) or 2 (we=11); we=10 is treated as n_wr=0.
- Write acceptance is all-or-nothing: accepted iff n_wr ≤ DEPTH − count, using count before this cycle's reads. A rejected request changes no state. Fetch only writes while wr_ready=1; a write with wr_ready=0 that still fits (n_wr=1, one slot free) is accepted.
- Accepted slot 0 goes to buf[w_ptr], slot 1 to buf[w_ptr+1]; w_ptr advances by n_wr.
- Read grant n_rd = min(requested, count) with requested = 0, 1 (re=01) or 2 (re=11); re=10 counts as 0. r_ptr advances by n_rd.
- count_next = count + n_wr_accepted − n_rd.
- Outputs rdata0_o/rdata1_o/rvalid/wr_ready/count_o are combinational from registered state. Data is don't-care while the matching rvalid bit is low.
- Priority: rst > flush > read/write. Flush zeroes w_ptr, r_ptr and count, and discards same-cycle reads and writes. Buffer contents are not cleared.

## Timing
- Reset values: rvalid=2'b00, count_o=0, wr_ready=1, pointers 0. rdata is don't-care.
- Write-to-read latency is 1 cycle. An entry written at edge N is visible at head from N onward and can be consumed in the following cycle. There is no same-cycle bypass.
- Full (count=DEPTH): all writes rejected; reads behave normally.
- Empty: reads are no-ops; a simultaneous write is accepted.
- Reads and writes in the same cycle never reuse a slot freed that cycle.
- Pointer wrap: with w_ptr=DEPTH−1 and a 2-wide write, slot 1 lands in buf[0]. The same wrap applies to r_ptr and rdata1_o.
- rst asserted mid-operation clears state immediately, without waiting for a clock edge. Deassertion takes effect at the next edge.

## Configuration
- `IQ_PERF_EN` defined: adds outputs perf_full_cycles_o (32 bits), perf_flush_cnt_o (32 bits) and perf_drop_cnt_o (32 bits).
  - perf_full_cycles_o counts cycles with wr_ready=0.
  - perf_flush_cnt_o counts cycles with flush=1.
  - perf_drop_cnt_o counts cycles with a rejected nonzero write.
  - All three saturate at 32'hFFFFFFFF, are cleared only by rst (flush does not clear them), and are readable combinationally from their registers.
- `IQ_PERF_EN` undefined: these ports and counters do not exist, and queue behaviour is identical.

## Test plan
- Reset then idle: rvalid=00, count_o=0, wr_ready=1. Assert rst asynchronously mid-fill at count=5: count_o=0 before the next edge.
- Two-wide fill, DEPTH=16, pc 0x0,0x4,…: 8 cycles of we=11 → count_o=16, wr_ready=0. A further we=01 is rejected, count_o stays 16, and perf_drop_cnt_o=1 with `IQ_PERF_EN`.
- Mixed traffic at count=3: we=11 with re=11 → count_o=3. Next head pc equals old head pc+8, and pred/pred_target come out intact.
- Underflow clip at count=1: re=11 → only one entry consumed, count_o=0, rvalid=00.
- Wrap: advance pointers to 15, write 0x100/0x104 with we=11 → rdata0_o.pc=0x100 and rdata1_o.pc=0x104 after the wrap. Illegal we=10 or re=10 → no state change.
- Flush at count=7 with concurrent we=11 and re=01 → count_o=0 and rvalid=00 on the next cycle, and the written entries are not visible.

Source files
------------

// File: rtl/instruction_queue_dual.sv
// Two-wide circular instruction queue between fetch and dual issue; flush clears it in one cycle.
// Optional IQ_PERF_EN adds saturating full-cycle, flush and dropped-write counters.
module instruction_queue_dual #(
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [1:0]           we,
  input  logic [96:0]          wdata0_i,
  input  logic [96:0]          wdata1_i,
  output logic                 wr_ready,
  input  logic [1:0]           re,
  output logic [96:0]          rdata0_o,
  output logic [96:0]          rdata1_o,
  output logic [1:0]           rvalid,
  output logic [PTR_WIDTH:0]   count_o
`ifdef IQ_PERF_EN
  ,
  output logic [31:0]          perf_full_cycles_o,
  output logic [31:0]          perf_flush_cnt_o,
  output logic [31:0]          perf_drop_cnt_o
`endif
);
  localparam int InstBus     = 32;
  localparam int InstAddrBus = 32;
  localparam int ENTRY_W     = 2 * InstAddrBus + 1 + InstBus;
  localparam int CW          = PTR_WIDTH + 1;

  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [CW-1:0]        count_q, count_d, free_w;
  logic [1:0]           n_wr, n_req, n_rd, n_wr_acc;
  logic                 wr_acc;

  // Upper enable bit is ignored unless the lower one is set.
  assign n_wr  = we[0] ? (we[1] ? 2'd2 : 2'd1) : 2'd0;
  assign n_req = re[0] ? (re[1] ? 2'd2 : 2'd1) : 2'd0;

  // Acceptance is judged against occupancy before this cycle's reads.
  assign free_w   = CW'(DEPTH) - count_q;
  assign wr_acc   = CW'(n_wr) <= free_w;
  assign n_wr_acc = wr_acc ? n_wr : 2'd0;
  assign n_rd     = (count_q >= CW'(n_req)) ? n_req : count_q[1:0];

  always_comb begin
    w_ptr_d = w_ptr_q + PTR_WIDTH'(n_wr_acc);
    r_ptr_d = r_ptr_q + PTR_WIDTH'(n_rd);
    count_d = count_q + CW'(n_wr_acc) - CW'(n_rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (n_wr_acc != 2'd0) mem_q[w_ptr_q] <= wdata0_i;
      if (n_wr_acc == 2'd2) mem_q[w_ptr_q + PTR_WIDTH'(1)] <= wdata1_i;
    end
  end

  assign rdata0_o = mem_q[r_ptr_q];
  assign rdata1_o = mem_q[r_ptr_q + PTR_WIDTH'(1)];
  assign rvalid   = {count_q >= CW'(2), count_q >= CW'(1)};
  assign wr_ready = free_w >= CW'(2);
  assign count_o  = count_q;

`ifdef IQ_PERF_EN
  logic [31:0] full_q, flush_q, drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= '0;
      flush_q <= '0;
      drop_q  <= '0;
    end else begin
      if (!wr_ready && full_q != '1) full_q <= full_q + 32'd1;
      if (flush && flush_q != '1) flush_q <= flush_q + 32'd1;
      if (n_wr != 2'd0 && !wr_acc && drop_q != '1) drop_q <= drop_q + 32'd1;
    end
  end

  assign perf_full_cycles_o = full_q;
  assign perf_flush_cnt_o   = flush_q;
  assign perf_drop_cnt_o    = drop_q;
`endif
endmodule

// File: tb/tb_instruction_queue_dual.sv
// Scoreboard bench for instruction_queue_dual: stimulus pushes hand-computed expectations,
// a monitor pops and compares them shortly after each rising edge.
module tb_instruction_queue_dual;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  we, re;
  logic [96:0] wdata0, wdata1, rdata0, rdata1;
  logic        wr_ready;
  logic [1:0]  rvalid;
  logic [4:0]  count;
`ifdef IQ_PERF_EN
  logic [31:0] perf_full, perf_flush, perf_drop;
`endif

  always #5 clk = ~clk;

  instruction_queue_dual #(.DEPTH(16), .PTR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .we(we),
    .wdata0_i(wdata0), .wdata1_i(wdata1), .wr_ready(wr_ready),
    .re(re), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .rvalid(rvalid), .count_o(count)
`ifdef IQ_PERF_EN
    , .perf_full_cycles_o(perf_full), .perf_flush_cnt_o(perf_flush),
    .perf_drop_cnt_o(perf_drop)
`endif
  );

  typedef struct {
    int          id;
    int          cnt;
    logic [1:0]  rv;
    logic        wrr;
    logic [31:0] pc0;
    logic [31:0] pc1;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   sid = 0;

  // Entry derived from its pc so pred/pred_target/inst all get checked.
  function automatic logic [96:0] mk(input logic [31:0] pc);
    logic [31:0] tgt;
    tgt = pc + 32'h0000_1000;
    return {tgt, pc[2], pc, pc ^ 32'hDEAD_0000};
  endfunction

  task automatic cmp(input string nm, input int id, input logic [96:0] act, input logic [96:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s step%0d: got %h expected %h", nm, id, act, want);
    end
  endtask

  task automatic check_state(input exp_t e);
    cmp("count", e.id, 97'(count), 97'(e.cnt));
    cmp("rvalid", e.id, 97'(rvalid), 97'(e.rv));
    cmp("wr_ready", e.id, 97'(wr_ready), 97'(e.wrr));
    if (e.rv[0]) cmp("rdata0", e.id, rdata0, mk(e.pc0));
    if (e.rv[1]) cmp("rdata1", e.id, rdata1, mk(e.pc1));
  endtask

  // Monitor: after every edge, settle then compare whatever the stimulus queued.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0) check_state(sb.pop_front());
    end
  end

  function automatic exp_t ex(input int c, input logic [31:0] p0, input logic [31:0] p1);
    exp_t e;
    e.id  = sid;
    e.cnt = c;
    e.rv  = {c >= 2, c >= 1};
    e.wrr = (16 - c) >= 2;
    e.pc0 = p0;
    e.pc1 = p1;
    return e;
  endfunction

  task automatic step(input logic [1:0] w, input logic [1:0] r, input logic f,
                      input logic [31:0] p0, input logic [31:0] p1,
                      input int c, input logic [31:0] e0, input logic [31:0] e1);
    @(negedge clk);
    we = w; re = r; flush = f; wdata0 = mk(p0); wdata1 = mk(p1);
    sid++;
    @(posedge clk);
    sb.push_back(ex(c, e0, e1));
  endtask

  task automatic idle();
    @(negedge clk);
    we = 2'b00; re = 2'b00; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; we = 2'b00; re = 2'b00; wdata0 = '0; wdata1 = '0;
    #1;
    check_state(ex(0, 0, 0));
    @(negedge clk); rst = 1'b0;

    // Fill to 5, then asynchronous reset between edges.
    step(2'b11, 2'b00, 0, 32'h0, 32'h4, 2, 32'h0, 32'h4);
    step(2'b11, 2'b00, 0, 32'h8, 32'hC, 4, 32'h0, 32'h4);
    step(2'b01, 2'b00, 0, 32'h10, 32'h0, 5, 32'h0, 32'h4);
    idle();
    #2 rst = 1'b1;
    #1 check_state(ex(0, 0, 0));
    @(negedge clk); rst = 1'b0;

    // Two-wide fill to full.
    for (int k = 1; k <= 8; k++)
      step(2'b11, 2'b00, 0, 32'(8*(k-1)), 32'(8*(k-1)+4), 2*k, 32'h0, 32'h4);
    step(2'b01, 2'b00, 0, 32'h40, 32'h0, 16, 32'h0, 32'h4);
    idle();
`ifdef IQ_PERF_EN
    cmp("perf_drop", sid, 97'(perf_drop), 97'd1);
`endif

    // Drain to 3: heads advance through 0x30, then 0x34.
    for (int k = 1; k <= 6; k++)
      step(2'b00, 2'b11, 0, 0, 0, 16 - 2*k, 32'(8*k), 32'(8*k+4));
    step(2'b00, 2'b01, 0, 0, 0, 3, 32'h34, 32'h38);

    // Mixed traffic at count 3; rdata1 wraps from r_ptr 15 to buf[0].
    step(2'b11, 2'b11, 0, 32'h80, 32'h84, 3, 32'h3C, 32'h80);
    // Illegal upper-only enables change nothing.
    step(2'b10, 2'b10, 0, 32'h200, 32'h204, 3, 32'h3C, 32'h80);
    step(2'b00, 2'b11, 0, 0, 0, 1, 32'h84, 32'h0);
    // Underflow clip.
    step(2'b00, 2'b11, 0, 0, 0, 0, 32'h0, 32'h0);

    // Walk both pointers from 2 to 15.
    for (int k = 1; k <= 6; k++)
      step(2'b11, 2'b00, 0, 32'(32'h300 + 8*(k-1)), 32'(32'h304 + 8*(k-1)), 2*k, 32'h300, 32'h304);
    step(2'b01, 2'b00, 0, 32'h330, 32'h0, 13, 32'h300, 32'h304);
    for (int k = 1; k <= 6; k++)
      step(2'b00, 2'b11, 0, 0, 0, 13 - 2*k, 32'(32'h300 + 8*k), 32'(32'h304 + 8*k));
    step(2'b00, 2'b01, 0, 0, 0, 0, 32'h0, 32'h0);
    // Write wrap: slot 1 lands in buf[0].
    step(2'b11, 2'b00, 0, 32'h100, 32'h104, 2, 32'h100, 32'h104);

    // Build to 7, then flush with concurrent write and read.
    step(2'b11, 2'b00, 0, 32'h108, 32'h10C, 4, 32'h100, 32'h104);
    step(2'b11, 2'b00, 0, 32'h110, 32'h114, 6, 32'h100, 32'h104);
    step(2'b01, 2'b00, 0, 32'h118, 32'h0, 7, 32'h100, 32'h104);
    step(2'b11, 2'b01, 1, 32'h500, 32'h504, 0, 32'h0, 32'h0);
    step(2'b00, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0);
    step(2'b01, 2'b00, 0, 32'h600, 32'h0, 1, 32'h600, 32'h0);
    idle();

    // Let the monitor drain, bounded.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
